// File: rtl/non_restore_divider_param.sv
// non_restore_divider_param: sequential non-restoring divider, one quotient bit per clock
//   DW           operand / result width (DW >= 2)
//   clk, n_rst   rising-edge clock, asynchronous active-low reset
//   start        request, sampled only while idle
//   dividend     dividend operand, latched on accept
//   divisor      divisor operand, latched on accept
//   signed_mode  two's-complement operands (honoured only when DIV_SIGNED_EN is defined)
//   busy         high from the cycle after accept until done rises
//   done         one-cycle result-valid strobe
//   quotient     result quotient, held until the next done
//   remainder    result remainder, held until the next done
//   div_by_zero  latched divisor was zero; cleared on the next accept
// Defining DIV_SIGNED_EN adds magnitude conversion on accept and sign fix-up in FIX.
module non_restore_divider_param #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    input  logic          signed_mode,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);
    localparam int CW = $clog2(DW);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
    state_t        state, state_nx;
    logic [DW:0]   acc, acc_sh, acc_step;
    logic [DW-1:0] q, m, acc_fix, dvd_mag, dsr_mag, rem_mag, quo_res, rem_res;
    logic [CW-1:0] cnt;
    logic          dz, accept;
    assign accept = state == S_IDLE && start;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= S_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? ((divisor == '0) ? S_FIX : S_CALC) : S_IDLE;
            S_CALC:  state_nx = (cnt == CW'(DW - 1)) ? S_FIX : S_CALC;
            S_FIX:   state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end
    // {A,Q} shifts left; the sign of A before the shift picks subtract or add
    assign acc_sh   = {acc[DW-1:0], q[DW-1]};
    assign acc_step = acc[DW] ? acc_sh + {1'b0, m} : acc_sh - {1'b0, m};
    assign acc_fix  = acc[DW] ? acc[DW-1:0] + m : acc[DW-1:0];
    // on divide-by-zero Q still holds the dividend magnitude, which becomes the remainder
    assign rem_mag  = dz ? q : acc_fix;
`ifdef DIV_SIGNED_EN
    logic neg_n, neg_d;
    assign dvd_mag = (signed_mode && dividend[DW-1]) ? -dividend : dividend;
    assign dsr_mag = (signed_mode && divisor[DW-1]) ? -divisor : divisor;
    // quotient truncates toward zero; remainder follows the dividend's sign
    assign quo_res = dz ? '1 : ((neg_n ^ neg_d) ? -q : q);
    assign rem_res = neg_n ? -rem_mag : rem_mag;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            neg_n <= 1'b0;
            neg_d <= 1'b0;
        end else if (accept) begin
            neg_n <= signed_mode && dividend[DW-1];
            neg_d <= signed_mode && divisor[DW-1];
        end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign dvd_mag = dividend;
    assign dsr_mag = divisor;
    assign quo_res = dz ? '1 : q;
    assign rem_res = rem_mag;
`endif
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            acc         <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= state == S_DONE;
            if (accept) begin
                acc         <= '0;
                q           <= dvd_mag;
                m           <= dsr_mag;
                cnt         <= '0;
                dz          <= divisor == '0;
                busy        <= 1'b1;
                div_by_zero <= 1'b0;
            end
            if (state == S_CALC) begin
                acc <= acc_step;
                q   <= {q[DW-2:0], ~acc_step[DW]};
                cnt <= cnt + 1'b1;
            end
            if (state == S_FIX) begin
                acc <= {1'b0, rem_res};
                q   <= quo_res;
            end
            if (state == S_DONE) begin
                busy        <= 1'b0;
                quotient    <= q;
                remainder   <= acc[DW-1:0];
                div_by_zero <= dz;
            end
        end
endmodule
